// File: rtl/serial_tx_shifter_pkg.sv
// Shared state encoding and default word width for the serial transmitter.
// Latency: none. Backpressure: none.
// Holds only declarations; nothing is clocked here.
package serial_tx_shifter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit counter for the serial transmitter: clear has priority over increment.
// Latency: 1 clock from clr/inc to count. Backpressure: inc low holds the count.
// Asynchronous active-low reset clears the count.
module tx_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial shifter: loads a word on start, emits one bit per enabled cycle.
// Latency: first bit on q one clock after start is accepted; done one cycle after last bit.
// Backpressure: en=0 freezes the word in place; start is ignored while busy.
module serial_tx_shifter
    import serial_tx_shifter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    output logic             q,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shifted;
    logic             q_nxt, valid_nxt, busy_nxt, done_nxt;
    logic             cnt_clr, cnt_inc, last_bit;
    logic             first_bit, next_bit;
    logic [CW-1:0]    count;

    tx_bit_counter #(
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count)
    );

    // count tracks bits already presented beyond the first, so it tops out at WIDTH-1
    assign last_bit     = (count == CW'(WIDTH - 1));
    assign first_bit    = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign next_bit     = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            q     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            q     <= q_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        q_nxt     = q;
        valid_nxt = valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = data_in;
                    cnt_clr   = 1'b1;
                    q_nxt     = first_bit;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    q_nxt     = 1'b0;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (last_bit) begin
                        state_nxt = DONE;
                        q_nxt     = 1'b0;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        sreg_nxt  = sreg_shifted;
                        q_nxt     = next_bit;
                        cnt_inc   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                q_nxt     = 1'b0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a queue-based
// model predicts per-cycle outputs and whole words, a monitor pops and compares.
module tb_serial_tx_shifter;

    localparam int W = 8;

    typedef struct packed {
        logic q_m;
        logic q_l;
        logic valid;
        logic busy;
        logic done;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         q_m, valid_m, busy_m, done_m;
    logic         q_l, valid_l, busy_l, done_l;

    rec_t         exp_q[$];
    logic [W-1:0] words[$];
    int           checks = 0;
    int           errors = 0;
    int           words_checked = 0;

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .en(en),
        .q(q_m), .valid(valid_m), .busy(busy_m), .done(done_m)
    );

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .en(en),
        .q(q_l), .valid(valid_l), .busy(busy_l), .done(done_l)
    );

    initial forever #5 clk = ~clk;

    // Reference model: a word is a queue of bits in transmit order; the head is on q.
    initial begin
        logic bits_m[$];
        logic bits_l[$];
        logic active;
        logic m_done;
        logic rst_prev;
        rec_t r;
        active   = 1'b0;
        rst_prev = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                bits_m.delete();
                bits_l.delete();
                words.delete();
                active = 1'b0;
                if (rst_prev) begin
                    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
                end else begin
                    exp_q.push_back('0);
                end
                rst_prev = 1'b0;
            end else begin
                rst_prev = 1'b1;
                m_done   = 1'b0;
                if (active) begin
                    if (en) begin
                        void'(bits_m.pop_front());
                        void'(bits_l.pop_front());
                        if (bits_m.size() == 0) begin
                            active = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end else if (start) begin
                    for (int i = 0; i < W; i++) begin
                        bits_m.push_back(data_in[W-1-i]);
                        bits_l.push_back(data_in[i]);
                    end
                    words.push_back(data_in);
                    active = 1'b1;
                end
                r.valid = active;
                r.busy  = active;
                r.done  = m_done;
                r.q_m   = active ? bits_m[0] : 1'b0;
                r.q_l   = active ? bits_l[0] : 1'b0;
                exp_q.push_back(r);
            end
        end
    end

    // Monitor: per-cycle output compare, word reassembly on done, immediate-reset check.
    initial begin
        rec_t         r;
        logic [W-1:0] asm_m, asm_l, w;
        int           nbits;
        asm_m = '0;
        asm_l = '0;
        nbits = 0;
        forever begin
            @(negedge clk or negedge rst);
            if (clk) begin
                #1;
                checks++;
                if ({q_m, valid_m, busy_m, done_m, q_l, valid_l, busy_l, done_l} !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_immediate t=%0t got msb=%b%b%b%b lsb=%b%b%b%b required all 0",
                             $time, q_m, valid_m, busy_m, done_m, q_l, valid_l, busy_l, done_l);
                end
                nbits = 0;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0t no expected record", $time);
            end else begin
                r = exp_q.pop_front();
                checks++;
                if ({q_m, valid_m, busy_m, done_m} !== {r.q_m, r.valid, r.busy, r.done}) begin
                    errors++;
                    $display("FAIL cycle_msb t=%0t got q/valid/busy/done=%b%b%b%b required %b%b%b%b",
                             $time, q_m, valid_m, busy_m, done_m, r.q_m, r.valid, r.busy, r.done);
                end
                checks++;
                if ({q_l, valid_l, busy_l, done_l} !== {r.q_l, r.valid, r.busy, r.done}) begin
                    errors++;
                    $display("FAIL cycle_lsb t=%0t got q/valid/busy/done=%b%b%b%b required %b%b%b%b",
                             $time, q_l, valid_l, busy_l, done_l, r.q_l, r.valid, r.busy, r.done);
                end
                if (!rst) begin
                    nbits = 0;
                end else begin
                    if (valid_m && en) begin
                        asm_m = {asm_m[W-2:0], q_m};
                        asm_l = {q_l, asm_l[W-1:1]};
                        nbits++;
                    end
                    if (done_m) begin
                        checks++;
                        if (words.size() == 0) begin
                            errors++;
                            $display("FAIL word_unexpected t=%0t done with no word in flight", $time);
                        end else begin
                            w = words.pop_front();
                            words_checked++;
                            if (asm_m !== w || asm_l !== w || nbits != W) begin
                                errors++;
                                $display("FAIL word t=%0t got msb=%h lsb=%h bits=%0d required %h bits=%0d",
                                         $time, asm_m, asm_l, nbits, w, W);
                            end
                        end
                        nbits = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic s, input logic [W-1:0] d, input logic e);
        start   = s;
        data_in = d;
        en      = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // A5 in both bit orders, data_in scrambled after acceptance
        drive(1'b1, 8'hA5, 1'b1);
        repeat (9) drive(1'b0, W'($urandom), 1'b1);
        drive(1'b0, '0, 1'b0);

        // F0 with a three-cycle pause after the third bit
        drive(1'b1, 8'hF0, 1'b1);
        repeat (2) drive(1'b0, W'($urandom), 1'b1);
        repeat (3) drive(1'b0, W'($urandom), 1'b0);
        repeat (7) drive(1'b0, W'($urandom), 1'b1);

        // FF with an ignored mid-word start of 00
        drive(1'b1, 8'hFF, 1'b1);
        repeat (2) drive(1'b0, W'($urandom), 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        repeat (8) drive(1'b0, 8'h00, 1'b1);

        // 3C then C3 with start held through DONE
        drive(1'b1, 8'h3C, 1'b1);
        repeat (9) drive(1'b1, 8'hC3, 1'b1);
        repeat (10) drive(1'b0, W'($urandom), 1'b1);

        // reset after the fourth bit aborts the word
        drive(1'b1, W'($urandom), 1'b1);
        repeat (3) drive(1'b0, W'($urandom), 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) drive(1'b0, W'($urandom), 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, W'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (12) drive(1'b0, '0, 1'b1);

        checks++;
        if (words_checked < 5) begin
            errors++;
            $display("FAIL words_completed got %0d required at least 5", words_checked);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
